// File: rtl/adrv9001_tx_feeder.sv
// TX feeder ahead of the ADRV9001 channel: FIFO with start-threshold priming,
// fixed-length bursts, zero-fill on underflow. Single clock (channel s_axis_aclk).
module adrv9001_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int START_LEVEL = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [31:0]              burst_len,
    input  logic [31:0]              s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [31:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     active,
    output logic                     done,
    output logic [15:0]              underflow_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] burst_len_q;
    logic [31:0] sample_cnt;
    logic        zero_hold;

    logic full, empty, zero_sel, xfer, push, pop, burst_end, flush;

    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == LVL_W'(DEPTH));
    assign empty      = (fifo_level == '0);
    // Once a zero-fill is offered and stalled, keep offering zero until it
    // transfers so the data stays stable even if a word lands meanwhile.
    assign zero_sel   = empty || zero_hold;
    assign xfer       = m_axis_tvalid && m_axis_tready;
    assign push       = s_axis_tvalid && s_axis_tready;
    assign pop        = xfer && !zero_sel;
    assign burst_end  = (burst_len_q != 32'd0) && (sample_cnt + 32'd1 == burst_len_q);
    assign flush      = (state_nxt == IDLE);

    assign m_axis_tdata = (m_axis_tvalid && !zero_sel) ? mem[rd_ptr[AW-1:0]] : 32'd0;

    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        active        = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = PRIME;
            end
            PRIME: begin
                s_axis_tready = enable && !full;
                if (fifo_level >= LVL_W'(START_LEVEL)) state_nxt = RUN;
            end
            RUN: begin
                s_axis_tready = enable && !full;
                m_axis_tvalid = 1'b1;
                active        = 1'b1;
                if (xfer && burst_end) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over everything, including a burst completing this cycle.
        if (!enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            burst_len_q   <= 32'd0;
            sample_cnt    <= 32'd0;
            underflow_cnt <= 16'd0;
            zero_hold     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            if (state == IDLE && enable) begin
                sample_cnt  <= 32'd0;
                burst_len_q <= burst_len;
            end else if (xfer) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
            if (xfer && zero_sel && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
            zero_hold <= m_axis_tvalid && !m_axis_tready && zero_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_adrv9001_tx_feeder.sv
// Scoreboard bench for adrv9001_tx_feeder: upstream pushes expected words,
// a negedge monitor checks every presented/transferred downstream word.
module tb_adrv9001_tx_feeder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] burst_len = 32'd0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        active, done;
    logic [15:0] underflow_cnt;
    logic [4:0]  fifo_level;

    adrv9001_tx_feeder #(.DEPTH(DEPTH), .START_LEVEL(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .burst_len(burst_len),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .active(active), .done(done), .underflow_cnt(underflow_cnt), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // Upstream source: ramp words, limited by up_budget; accepted words go to the scoreboard.
    logic [31:0] exp_q[$];
    int          up_budget = 0;
    logic [31:0] ramp = 32'h0001_0001;
    initial begin
        logic hs;
        s_axis_tdata = ramp;
        forever begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            if (hs) begin
                exp_q.push_back(s_axis_tdata);
                ramp = ramp + 32'h0001_0001;
                up_budget--;
            end
            #1;
            s_axis_tvalid = (up_budget > 0);
            s_axis_tdata  = ramp;
        end
    end

    // Downstream ready toggles every cycle when enabled.
    logic rdy_tog = 1'b0;
    initial forever begin
        @(posedge clk); #1;
        if (rdy_tog) m_axis_tready = !m_axis_tready;
    end

    // Monitor: empty scoreboard (or a stalled zero) means a zero-fill is expected.
    int xfers = 0, data_xfers = 0, done_cnt = 0, uf_model = 0;
    bit prev_zero = 1'b0;
    initial forever begin
        bit exp_zero, xf;
        @(negedge clk);
        if (!rst) begin
            xf       = m_axis_tvalid && m_axis_tready;
            exp_zero = prev_zero || (exp_q.size() == 0);
            if (m_axis_tvalid && enable) begin
                check("m_tdata", m_axis_tdata, exp_zero ? 32'd0 : exp_q[0]);
                if (xf) begin
                    xfers++;
                    if (!exp_zero) begin
                        void'(exp_q.pop_front());
                        data_xfers++;
                    end
                end
            end
            if (xf && exp_zero && uf_model < 65535) uf_model++;
            prev_zero = m_axis_tvalid && !m_axis_tready && exp_zero;
            if (done) done_cnt++;
            if (!enable || done) begin
                exp_q.delete();
                prev_zero = 1'b0;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen8;
        int t;
        // 1. reset then idle
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_s_tready", 32'(s_axis_tready), 32'd0);
            check("idle_flags", {29'd0, m_axis_tvalid, active, done}, 32'd0);
            if (i == 0) begin
                check("rst_tdata", m_axis_tdata, 32'd0);
                check("rst_uf", 32'(underflow_cnt), 32'd0);
                check("rst_level", 32'(fifo_level), 32'd0);
            end
        end

        // 2. priming threshold and full backpressure
        step();
        burst_len = 32'd20;
        up_budget = 1_000_000;
        enable    = 1'b1;
        step();
        seen8 = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            check("prime_tvalid", 32'(m_axis_tvalid), 32'(seen8));
            check("prime_full_tready", 32'(s_axis_tready), 32'(fifo_level != 5'd16));
            if (fifo_level >= 5'd8) seen8 = 1'b1;
        end
        check("prime_level_full", 32'(fifo_level), 32'd16);

        // 3. 20-sample burst with alternating ready
        step();
        rdy_tog = 1'b1;
        t = 0;
        while (!done && t < 400) begin @(negedge clk); t++; end
        check("burst_done_seen", 32'(done), 32'd1);
        check("burst_xfers", 32'(xfers), 32'd20);
        @(negedge clk);
        check("burst_flush_level", 32'(fifo_level), 32'd0);
        check("burst_idle_done", 32'(done), 32'd0);
        check("burst_idle_tready", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        check("burst_rearm_tready", 32'(s_axis_tready), 32'd1);
        check("burst_done_cnt", 32'(done_cnt), 32'd1);

        // 4. continuous mode with upstream underflow, then resume
        step();
        enable    = 1'b0;
        up_budget = 0;
        step(3);
        burst_len  = 32'd0;
        up_budget  = 10;
        xfers      = 0;
        data_xfers = 0;
        enable     = 1'b1;
        step(60);
        check("uf_data_words", 32'(data_xfers), 32'd10);
        check("uf_count", 32'(underflow_cnt), 32'(uf_model));
        check("uf_still_active", 32'(active), 32'd1);
        up_budget = 12;
        step(80);
        check("resume_data_words", 32'(data_xfers), 32'd22);
        check("resume_uf_count", 32'(underflow_cnt), 32'(uf_model));

        // 5. abort mid-burst after 30 transfers
        enable    = 1'b0;
        up_budget = 0;
        step(3);
        burst_len = 32'd100;
        up_budget = 1_000_000;
        xfers     = 0;
        enable    = 1'b1;
        t = 0;
        while (xfers < 30 && t < 500) begin @(posedge clk); t++; end
        #2 enable = 1'b0;
        check("abort_xfers", 32'(xfers), 32'd30);
        @(posedge clk);
        @(negedge clk);
        check("abort_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("abort_level", 32'(fifo_level), 32'd0);
        check("abort_active", 32'(active), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_done_cnt", 32'(done_cnt), 32'd1);

        // 6. underflow counter saturation
        step();
        up_budget     = 8;
        burst_len     = 32'd0;
        rdy_tog       = 1'b0;
        m_axis_tready = 1'b0;
        step(2);
        enable = 1'b1;
        t = 0;
        while (!active && t < 100) begin @(negedge clk); t++; end
        check("sat_active", 32'(active), 32'd1);
        @(posedge clk);
        #2 m_axis_tready = 1'b1;
        repeat (70010) @(posedge clk);
        @(negedge clk);
        check("sat_uf_cnt", 32'(underflow_cnt), 32'h0000_FFFF);
        step(5);
        @(negedge clk);
        check("sat_uf_hold", 32'(underflow_cnt), 32'h0000_FFFF);
        enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
